// File: rtl/rv_pkg.sv
// Shared constants for the write-back stage: data width, load funct3
// encodings, the hard-wired zero register and the arbitration winner type.
package rv_pkg;

    localparam int XLEN = 32;

    // Load funct3 encodings as they arrive from the load unit
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // x0 is never written; results targeting it are consumed and dropped
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the tag part of a buffered load entry (rd + funct3)
    localparam int LD_TAG_W = 5 + 3;

    // Which source owns the register-file write port this cycle
    typedef enum logic [1:0] {
        WIN_IDLE = 2'd0,
        WIN_ALU  = 2'd1,
        WIN_LD   = 2'd2
    } wb_win_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for buffered load responses. Head entry is visible
// combinationally on dout so the consumer can act on it in the pop cycle.
// full/empty come from the registered occupancy count only.
module wb_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Next pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole owner of the register-file write port. ALU results
// normally win; buffered load responses take the port when the ALU is quiet or
// after STARVE_MAX consecutive losses. Loads are extended on their way out of
// the FIFO, and a per-register pending-load mask feeds the decode hazard check.
module wb_arbiter #(
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     pend_mask,
    output logic            we3,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3
);

    import rv_pkg::*;

    localparam int ENT_W = LD_TAG_W + XLEN;
    localparam int SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_din;
    logic [ENT_W-1:0] fifo_dout;

    // Decoded head entry
    logic [4:0]       head_rd;
    logic [2:0]       head_funct3;
    logic [XLEN-1:0]  head_data;
    logic [XLEN-1:0]  ld_ext;

    // Arbitration
    wb_win_e          win;
    logic             force_ld;
    logic [SC_W-1:0]  starve_cnt_reg, starve_cnt_next;

    // Output registers
    logic             we3_reg, we3_next;
    logic [4:0]       a3_reg, a3_next;
    logic [XLEN-1:0]  wd3_reg, wd3_next;

    assign fifo_din  = {ld_rd, ld_funct3, ld_data};
    assign {head_rd, head_funct3, head_data} = fifo_dout;

    // Ready depends only on registered occupancy, never on ld_valid
    assign ld_ready  = !fifo_full;
    assign fifo_push = ld_valid && ld_ready;

    assign force_ld  = !fifo_empty && (starve_cnt_reg == SC_W'(STARVE_MAX));
    assign alu_ready = !force_ld;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pick one winner: ALU first (unless forced out), then the FIFO head
    always_comb begin
        win = WIN_IDLE;
        if (alu_valid && alu_ready) begin
            win = WIN_ALU;
        end else if (!fifo_empty) begin
            win = WIN_LD;
        end
    end

    assign fifo_pop = (win == WIN_LD);

    // Sign/zero-extend the head entry according to its load type
    always_comb begin
        ld_ext = head_data;
        case (head_funct3)
            F3_LB:   ld_ext = {{(XLEN-8){head_data[7]}},   head_data[7:0]};
            F3_LH:   ld_ext = {{(XLEN-16){head_data[15]}}, head_data[15:0]};
            F3_LBU:  ld_ext = {{(XLEN-8){1'b0}},           head_data[7:0]};
            F3_LHU:  ld_ext = {{(XLEN-16){1'b0}},          head_data[15:0]};
            F3_LW:   ld_ext = head_data;
            default: ld_ext = head_data;
        endcase
    end

    // Starvation counter: counts ALU wins over a waiting load, saturating
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_next = '0;
        end else if ((win == WIN_ALU) && (starve_cnt_reg != SC_W'(STARVE_MAX))) begin
            starve_cnt_next = starve_cnt_reg + SC_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Next write-port values; address/data hold when nothing is written
    always_comb begin
        we3_next = 1'b0;
        a3_next  = a3_reg;
        wd3_next = wd3_reg;
        case (win)
            WIN_ALU: begin
                if (alu_rd != REG_X0) begin
                    we3_next = 1'b1;
                    a3_next  = alu_rd;
                    wd3_next = alu_data;
                end
            end
            WIN_LD: begin
                if (head_rd != REG_X0) begin
                    we3_next = 1'b1;
                    a3_next  = head_rd;
                    wd3_next = ld_ext;
                end
            end
            default: begin
                we3_next = 1'b0;
            end
        endcase
    end

    // Registered write port, one cycle after arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_reg <= 1'b0;
            a3_reg  <= '0;
            wd3_reg <= '0;
        end else begin
            we3_reg <= we3_next;
            a3_reg  <= a3_next;
            wd3_reg <= wd3_next;
        end
    end

    assign we3 = we3_reg;
    assign A3  = a3_reg;
    assign WD3 = wd3_reg;

    // Pending-load mask: one flop per register, x0 tied low
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pend_mask[gi] = 1'b0;
            end else begin : g_xn
                logic pend_reg;
                logic set_hit;
                logic clr_hit;

                assign set_hit = iss_valid && (iss_rd == 5'(gi));
                assign clr_hit = fifo_pop && (head_rd == 5'(gi));

                // A new issue to the same register beats the pop of the older load
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pend_reg <= 1'b0;
                    end else if (set_hit) begin
                        pend_reg <= 1'b1;
                    end else if (clr_hit) begin
                        pend_reg <= 1'b0;
                    end
                end

                assign pend_mask[gi] = pend_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: each scenario task drives stimulus, pushes the
// register-file writes it expects onto a queue, and compares every observed
// we3 pulse against the queue head at the falling edge.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] pend_mask;
    logic        we3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    wb_arbiter #(
        .XLEN       (32),
        .LD_DEPTH   (2),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_funct3 (ld_funct3),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .pend_mask (pend_mask),
        .we3       (we3),
        .A3        (A3),
        .WD3       (WD3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_funct3 = 3'd0; ld_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({we3, A3, WD3, pend_mask} !== {1'b0, 5'd0, 32'd0, 32'd0})
            $display("FAIL reset_outputs got we3=%b A3=%0d WD3=%h pend=%h want all zero", we3, A3, WD3, pend_mask);
        else passed++;
        checks++;
        if ({ld_ready, alu_ready} !== 2'b11)
            $display("FAIL reset_ready got ld_ready=%b alu_ready=%b want 1 1", ld_ready, alu_ready);
        else passed++;
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_alu();
        wr_t e;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive_idle();
            if (c == 0) begin
                alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5;
                exp_q.push_back('{a: 5'd5, d: 32'h5});
            end else if (c == 1) begin
                alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
            end else if (c == 2) begin
                alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 32'hCAFE0001;
                exp_q.push_back('{a: 5'd31, d: 32'hCAFE0001});
            end
            @(negedge clk);
            if (c <= 2) begin
                checks++;
                if (alu_ready !== 1'b1) $display("FAIL alu_ready_c%0d got %b want 1", c, alu_ready);
                else passed++;
            end
            if (c == 2) begin
                checks++;
                if (we3 !== 1'b0) $display("FAIL alu_rd0_we3 got %b want 0", we3);
                else passed++;
            end
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_alu_unexpected got A3=%0d WD3=%h want no write", A3, WD3);
                end else begin
                    e = exp_q.pop_front();
                    if (A3 !== e.a || WD3 !== e.d)
                        $display("FAIL sb_alu got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
                    else passed++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_alu_drain got %0d left want 0", exp_q.size());
        else passed++;
        exp_q.delete();
        $display("test_alu: done");
    endtask

    task automatic test_load_ext();
        wr_t e;
        logic [4:0]  t_rd;
        logic [2:0]  t_f3;
        logic [31:0] t_d;
        logic [31:0] t_x;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            drive_idle();
            if (c < 7) begin
                case (c)
                    0: begin t_rd = 5'd10; t_f3 = 3'b000; t_d = 32'h00000080; t_x = 32'hFFFFFF80; end
                    1: begin t_rd = 5'd11; t_f3 = 3'b100; t_d = 32'h00000080; t_x = 32'h00000080; end
                    2: begin t_rd = 5'd12; t_f3 = 3'b001; t_d = 32'h00008000; t_x = 32'hFFFF8000; end
                    3: begin t_rd = 5'd13; t_f3 = 3'b010; t_d = 32'hDEADBEEF; t_x = 32'hDEADBEEF; end
                    4: begin t_rd = 5'd14; t_f3 = 3'b101; t_d = 32'hFFFF8001; t_x = 32'h00008001; end
                    5: begin t_rd = 5'd15; t_f3 = 3'b000; t_d = 32'h1234567F; t_x = 32'h0000007F; end
                    default: begin t_rd = 5'd16; t_f3 = 3'b011; t_d = 32'hCAFEF00D; t_x = 32'hCAFEF00D; end
                endcase
                ld_valid = 1'b1; ld_rd = t_rd; ld_funct3 = t_f3; ld_data = t_d;
                exp_q.push_back('{a: t_rd, d: t_x});
            end
            @(negedge clk);
            if (c < 7) begin
                checks++;
                if (ld_ready !== 1'b1) $display("FAIL ext_ld_ready_c%0d got %b want 1", c, ld_ready);
                else passed++;
            end
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_ext_unexpected got A3=%0d WD3=%h want no write", A3, WD3);
                end else begin
                    e = exp_q.pop_front();
                    if (A3 !== e.a || WD3 !== e.d)
                        $display("FAIL sb_ext got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
                    else passed++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_ext_drain got %0d left want 0", exp_q.size());
        else passed++;
        exp_q.delete();
        $display("test_load_ext: done");
    endtask

    task automatic test_starvation();
        wr_t  e;
        logic want_rdy;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            drive_idle();
            if (c == 0) begin
                alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
                ld_valid = 1'b1; ld_rd = 5'd20; ld_funct3 = 3'b010; ld_data = 32'hA5A5A5A5;
                exp_q.push_back('{a: 5'd1, d: 32'h100});
            end else if (c <= 3) begin
                alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_data = 32'h100 + 32'(c);
                exp_q.push_back('{a: 5'(c + 1), d: 32'h100 + 32'(c)});
            end else if (c == 4) begin
                alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h104;
                exp_q.push_back('{a: 5'd20, d: 32'hA5A5A5A5});
            end else if (c == 5) begin
                alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h104;
                exp_q.push_back('{a: 5'd5, d: 32'h104});
            end
            @(negedge clk);
            if (c <= 5) begin
                want_rdy = (c != 4);
                checks++;
                if (alu_ready !== want_rdy) $display("FAIL starve_alu_ready_c%0d got %b want %b", c, alu_ready, want_rdy);
                else passed++;
            end
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_starve_unexpected got A3=%0d WD3=%h want no write", A3, WD3);
                end else begin
                    e = exp_q.pop_front();
                    if (A3 !== e.a || WD3 !== e.d)
                        $display("FAIL sb_starve got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
                    else passed++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_starve_drain got %0d left want 0", exp_q.size());
        else passed++;
        exp_q.delete();
        $display("test_starvation: done");
    endtask

    task automatic test_back_pressure();
        wr_t  e;
        logic want_ld_rdy;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            drive_idle();
            if (c <= 4) begin
                alu_valid = 1'b1; alu_rd = 5'(21 + c); alu_data = 32'h500 + 32'(c);
                if (c <= 3) exp_q.push_back('{a: 5'(21 + c), d: 32'h500 + 32'(c)});
            end
            case (c)
                0: begin ld_valid = 1'b1; ld_rd = 5'd16; ld_funct3 = 3'b010; ld_data = 32'h11111111; end
                1: begin ld_valid = 1'b1; ld_rd = 5'd17; ld_funct3 = 3'b100; ld_data = 32'h000000FF; end
                2, 3, 4, 5: begin ld_valid = 1'b1; ld_rd = 5'd18; ld_funct3 = 3'b001; ld_data = 32'h00007FFF; end
                6: begin ld_valid = 1'b1; ld_rd = 5'd19; ld_funct3 = 3'b010; ld_data = 32'h44444444; end
                default: ld_valid = 1'b0;
            endcase
            case (c)
                4: exp_q.push_back('{a: 5'd16, d: 32'h11111111});
                5: exp_q.push_back('{a: 5'd17, d: 32'h000000FF});
                6: exp_q.push_back('{a: 5'd18, d: 32'h00007FFF});
                7: exp_q.push_back('{a: 5'd19, d: 32'h44444444});
                default: ;
            endcase
            @(negedge clk);
            if (c <= 7) begin
                want_ld_rdy = !(c >= 2 && c <= 4);
                checks++;
                if (ld_ready !== want_ld_rdy) $display("FAIL bp_ld_ready_c%0d got %b want %b", c, ld_ready, want_ld_rdy);
                else passed++;
            end
            if (c == 4) begin
                checks++;
                if (alu_ready !== 1'b0) $display("FAIL bp_alu_ready_c4 got %b want 0", alu_ready);
                else passed++;
            end
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_bp_unexpected got A3=%0d WD3=%h want no write", A3, WD3);
                end else begin
                    e = exp_q.pop_front();
                    if (A3 !== e.a || WD3 !== e.d)
                        $display("FAIL sb_bp got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
                    else passed++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_bp_drain got %0d left want 0", exp_q.size());
        else passed++;
        exp_q.delete();
        $display("test_back_pressure: done");
    endtask

    task automatic test_pend_mask();
        wr_t         e;
        logic [31:0] want_mask;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive_idle();
            case (c)
                0: begin iss_valid = 1'b1; iss_rd = 5'd6; end
                1: begin ld_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010; ld_data = 32'h66; end
                2: begin
                    iss_valid = 1'b1; iss_rd = 5'd6;
                    ld_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010; ld_data = 32'h67;
                    exp_q.push_back('{a: 5'd6, d: 32'h66});
                end
                3: begin
                    iss_valid = 1'b1; iss_rd = 5'd0;
                    exp_q.push_back('{a: 5'd6, d: 32'h67});
                end
                default: ;
            endcase
            @(negedge clk);
            if (c >= 1) begin
                want_mask = (c <= 3) ? 32'h0000_0040 : 32'h0000_0000;
                checks++;
                if (pend_mask !== want_mask) $display("FAIL pend_mask_c%0d got %h want %h", c, pend_mask, want_mask);
                else passed++;
            end
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_pend_unexpected got A3=%0d WD3=%h want no write", A3, WD3);
                end else begin
                    e = exp_q.pop_front();
                    if (A3 !== e.a || WD3 !== e.d)
                        $display("FAIL sb_pend got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
                    else passed++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_pend_drain got %0d left want 0", exp_q.size());
        else passed++;
        exp_q.delete();
        $display("test_pend_mask: done");
    endtask

    task automatic test_reset_midstream();
        wr_t e;
        // Cycle 0: ALU write plus a load that stays queued behind the ALU
        @(posedge clk); #1;
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_data = 32'h99;
        iss_valid = 1'b1; iss_rd = 5'd9;
        exp_q.push_back('{a: 5'd7, d: 32'h77});
        @(posedge clk); #1;
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        @(negedge clk);
        checks++;
        if (we3 !== 1'b1) begin
            $display("FAIL mid_we3_before got %b want 1", we3);
        end else begin
            e = exp_q.pop_front();
            if (A3 !== e.a || WD3 !== e.d)
                $display("FAIL mid_write got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, e.a, e.d);
            else passed++;
        end
        checks++;
        if (pend_mask !== 32'h0000_0200) $display("FAIL mid_pend_before got %h want 00000200", pend_mask);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({we3, A3, WD3, pend_mask} !== {1'b0, 5'd0, 32'd0, 32'd0})
            $display("FAIL mid_async_reset got we3=%b A3=%0d WD3=%h pend=%h want all zero", we3, A3, WD3, pend_mask);
        else passed++;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (we3 !== 1'b0 || ld_ready !== 1'b1)
                $display("FAIL mid_fifo_empty_c%0d got we3=%b ld_ready=%b want 0 1", c, we3, ld_ready);
            else passed++;
        end
        $display("test_reset_midstream: done");
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_alu();
        test_load_ext();
        test_starvation();
        test_back_pressure();
        test_pend_mask();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1, "time limit");
    end

endmodule
